// File: rtl/dbi_tx_frame_sched.sv
// Frame sequencer: emits CASET/PASET/RAMWR preamble, then passes exactly IMG_W*IMG_H*2 pixel bytes to the DBI TX FSM.
// Latency: command bytes come straight from state; pixel bytes are a zero-latency pass-through. Backpressure: tx_rdy_i stalls all bytes.
module dbi_tx_frame_sched #(
    parameter int DATA_W    = 8,
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 240,
    parameter int COL_START = 0,
    parameter int ROW_START = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] pxl_dat_i,
    input  logic              pxl_vld_i,
    output logic              pxl_rdy_o,
    output logic [DATA_W-1:0] tx_dat_o,
    output logic              tx_dc_o,
    output logic              tx_vld_o,
    input  logic              tx_rdy_i,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam longint TOTAL = longint'(IMG_W) * longint'(IMG_H) * 2;
    localparam int CNT_W = (TOTAL > 2) ? $clog2(TOTAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 1);

    localparam logic [15:0] COL_S = 16'(COL_START);
    localparam logic [15:0] COL_E = 16'(COL_START + IMG_W - 1);
    localparam logic [15:0] ROW_S = 16'(ROW_START);
    localparam logic [15:0] ROW_E = 16'(ROW_START + IMG_H - 1);

    typedef enum logic [2:0] {
        IDLE,
        CASET_C,
        CASET_D,
        PASET_C,
        PASET_D,
        RAMWR_C,
        PIXEL,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_hsk;

    // Address parameters go out big-endian: start hi/lo, then end hi/lo.
    function automatic logic [7:0] par_byte(input logic [15:0] s, input logic [15:0] e,
                                            input logic [1:0] i);
        case (i)
            2'd0:    par_byte = s[15:8];
            2'd1:    par_byte = s[7:0];
            2'd2:    par_byte = e[15:8];
            default: par_byte = e[7:0];
        endcase
    endfunction

    always_comb begin
        tx_vld_o  = 1'b0;
        tx_dc_o   = 1'b0;
        tx_dat_o  = '0;
        pxl_rdy_o = 1'b0;
        case (state_q)
            CASET_C: begin
                tx_vld_o = 1'b1;
                tx_dat_o = DATA_W'(8'h2A);
            end
            CASET_D: begin
                tx_vld_o = 1'b1;
                tx_dc_o  = 1'b1;
                tx_dat_o = DATA_W'(par_byte(COL_S, COL_E, idx_q));
            end
            PASET_C: begin
                tx_vld_o = 1'b1;
                tx_dat_o = DATA_W'(8'h2B);
            end
            PASET_D: begin
                tx_vld_o = 1'b1;
                tx_dc_o  = 1'b1;
                tx_dat_o = DATA_W'(par_byte(ROW_S, ROW_E, idx_q));
            end
            RAMWR_C: begin
                tx_vld_o = 1'b1;
                tx_dat_o = DATA_W'(8'h2C);
            end
            PIXEL: begin
                tx_vld_o  = pxl_vld_i;
                tx_dc_o   = 1'b1;
                tx_dat_o  = pxl_dat_i;
                pxl_rdy_o = tx_rdy_i;
            end
            default: ;
        endcase
    end

    assign tx_hsk       = tx_vld_o & tx_rdy_i;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    if (start_i) state_d = CASET_C;
            CASET_C: if (tx_hsk) state_d = CASET_D;
            CASET_D: if (tx_hsk) begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = PASET_C;
            end
            PASET_C: if (tx_hsk) state_d = PASET_D;
            PASET_D: if (tx_hsk) begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = RAMWR_C;
            end
            RAMWR_C: if (tx_hsk) state_d = PIXEL;
            PIXEL:   if (tx_hsk) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides any handshake-driven advance; the byte taken this cycle is still gone.
        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
